// File: rtl/fadd_pkg.sv
// Shared types for the fadd sharing scheduler: FP32 word and the in-flight owner tag.
package fadd_pkg;
  typedef logic [31:0] fp32_t;

  localparam int LATENCY_DEFAULT = 4;
  localparam int NREQ_MAX        = 8;
  localparam int ID_W            = $clog2(NREQ_MAX);

  typedef struct packed {
    logic            v;
    logic [ID_W-1:0] id;
  } tag_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts one past ptr and wraps; one-hot grant plus its index.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);
  int   idx;
  logic found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    idx     = 0;
    found   = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found        = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = IW'(idx);
      end
    end
  end
endmodule

// File: rtl/fadd_share_sched.sv
// Shares one fixed-latency pipelined FP32 adder among NREQ requesters; a tag pipe
// mirrors the adder depth so each result pulses back to its owner in issue order.
module fadd_share_sched
  import fadd_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int LATENCY = LATENCY_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NREQ-1:0]      req_valid,
  input  fp32_t [NREQ-1:0]     req_a,
  input  fp32_t [NREQ-1:0]     req_b,
  output logic [NREQ-1:0]      req_ready,
  output fp32_t                fadd_a,
  output fp32_t                fadd_b,
  input  fp32_t                fadd_c,
  output logic [NREQ-1:0]      res_valid,
  output fp32_t                res_data,
  output logic                 busy
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(LATENCY + 2);

  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   gnt_idx;
  logic            issue;

  logic [IW-1:0]   ptr_q, ptr_d;
  fp32_t           fadd_a_q, fadd_a_d;
  fp32_t           fadd_b_q, fadd_b_d;
  tag_t            tag0_d;
  tag_t            tag_q [LATENCY+1];
  logic [CW-1:0]   inflight_q, inflight_d;
  logic            retire;

  rr_arbiter #(.N(NREQ)) u_arb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Grants are masked while reset is held so nothing looks accepted.
  assign req_ready = gnt & {NREQ{rstn}};
  assign issue     = |gnt;
  assign retire    = tag_q[LATENCY].v;

  always_comb begin
    fadd_a_d = '0;
    fadd_b_d = '0;
    ptr_d    = ptr_q;
    tag0_d   = '0;
    if (issue) begin
      fadd_a_d  = req_a[gnt_idx];
      fadd_b_d  = req_b[gnt_idx];
      tag0_d.v  = 1'b1;
      tag0_d.id = ID_W'(gnt_idx);
      ptr_d     = gnt_idx;
    end
  end

  always_comb begin
    inflight_d = inflight_q;
    case ({issue, retire})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q      <= IW'(NREQ - 1);
      fadd_a_q   <= '0;
      fadd_b_q   <= '0;
      inflight_q <= '0;
      for (int i = 0; i <= LATENCY; i++) tag_q[i] <= '0;
    end else begin
      ptr_q      <= ptr_d;
      fadd_a_q   <= fadd_a_d;
      fadd_b_q   <= fadd_b_d;
      inflight_q <= inflight_d;
      tag_q[0]   <= tag0_d;
      for (int i = 1; i <= LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  always_comb begin
    res_valid = '0;
    for (int i = 0; i < NREQ; i++)
      res_valid[i] = tag_q[LATENCY].v && (tag_q[LATENCY].id == ID_W'(i));
  end

  assign fadd_a   = fadd_a_q;
  assign fadd_b   = fadd_b_q;
  assign res_data = fadd_c;
  assign busy     = (inflight_q != '0);
endmodule

// File: tb/tb_fadd_share_sched.sv
// Bench for fadd_share_sched: a stand-in adder pipe plus a queue-based reference of grants and results.
module tb_fadd_share_sched;
  import fadd_pkg::*;

  localparam int N = 4;
  localparam int L = 4;

  logic                clk = 1'b0;
  logic                rstn;
  logic [N-1:0]        req_valid;
  logic [N-1:0][31:0]  req_a, req_b;
  logic [N-1:0]        req_ready;
  logic [31:0]         fadd_a, fadd_b, fadd_c;
  logic [N-1:0]        res_valid;
  logic [31:0]         res_data;
  logic                busy;

  always #5 clk = ~clk;

  fadd_share_sched #(.NREQ(N), .LATENCY(L)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .fadd_a(fadd_a), .fadd_b(fadd_b), .fadd_c(fadd_c),
    .res_valid(res_valid), .res_data(res_data), .busy(busy)
  );

  // Known FP32 sums are exact; other pairs use an integer stand-in, enough to trace routing.
  function automatic logic [31:0] golden(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F800000 && b == 32'h3F800000) return 32'h40000000;
    if (a == 32'h3F800000 && b == 32'h34000000) return 32'h3F800001;
    if (a == 32'h3F800000 && b == 32'hB3800000) return 32'h3F7FFFFF;
    return a + b;
  endfunction

  logic [31:0] pipe [L];
  always @(posedge clk) begin
    pipe[0] <= golden(fadd_a, fadd_b);
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign fadd_c = pipe[L-1];

  typedef struct {
    int          due;
    int          id;
    logic [31:0] data;
  } exp_t;

  exp_t         q[$];
  int           checks   = 0;
  int           failures = 0;
  int           cyc      = 0;
  int           mptr     = N - 1;
  logic [31:0]  exp_fa   = '0;
  logic [31:0]  exp_fb   = '0;
  logic [N-1:0] g_log[$];
  logic [N-1:0] r_vld[$];
  logic [31:0]  r_dat[$];
  int           r_cyc[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 1; k <= N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic clear_logs();
    g_log.delete(); r_vld.delete(); r_dat.delete(); r_cyc.delete();
  endtask

  // One clock: compare at posedge+3, then advance the reference on the edge.
  task automatic cycle();
    int   g;
    logic bexp;
    exp_t e;
    #2;
    g    = pick(req_valid, mptr);
    bexp = (q.size() != 0);
    chk("req_ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
    chk("fadd_a", fadd_a, exp_fa);
    chk("fadd_b", fadd_b, exp_fb);
    chk("busy", {31'd0, busy}, {31'd0, bexp});
    if (q.size() != 0 && q[0].due == cyc) begin
      e = q.pop_front();
      chk("res_valid", 32'(res_valid), 32'd1 << e.id);
      chk("res_data", res_data, e.data);
    end else begin
      chk("res_valid_idle", 32'(res_valid), 32'd0);
    end
    if (req_ready != '0) g_log.push_back(req_ready);
    if (res_valid != '0) begin
      r_vld.push_back(res_valid); r_dat.push_back(res_data); r_cyc.push_back(cyc);
    end
    @(posedge clk);
    if (g >= 0) begin
      q.push_back('{cyc + L + 1, g, golden(req_a[g], req_b[g])});
      mptr   = g;
      exp_fa = req_a[g];
      exp_fb = req_b[g];
    end else begin
      exp_fa = '0;
      exp_fb = '0;
    end
    cyc++;
    #1;
  endtask

  task automatic apply_reset();
    rstn      = 1'b0;
    req_valid = '0;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_fadd_a", fadd_a, 32'd0);
    q.delete();
    mptr   = N - 1;
    exp_fa = '0;
    exp_fb = '0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      req_a[i] = $urandom;
      req_b[i] = $urandom;
    end
  endtask

  int hs;
  int n1, n3;

  initial begin
    rstn = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
    @(posedge clk); #1;
    apply_reset();

    // Single op
    clear_logs();
    req_valid = 4'b0001; req_a[0] = 32'h3F800000; req_b[0] = 32'h3F800000;
    hs = cyc;
    cycle();
    req_valid = '0;
    repeat (L + 3) cycle();
    chk("single_count", r_cyc.size(), 1);
    if (r_cyc.size() == 1) begin
      chk("single_latency", r_cyc[0] - hs, L + 1);
      chk("single_vld", 32'(r_vld[0]), 32'h1);
      chk("single_data", r_dat[0], 32'h40000000);
    end

    // All four valid for eight cycles
    apply_reset();
    clear_logs();
    req_valid = 4'hF;
    repeat (8) begin rand_ops(); cycle(); end
    req_valid = '0;
    repeat (L + 2) cycle();
    chk("all4_grants", g_log.size(), 8);
    chk("all4_results", r_vld.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < g_log.size()) chk("all4_gnt_order", 32'(g_log[i]), 32'd1 << (i % N));
      if (i < r_vld.size()) chk("all4_res_order", 32'(r_vld[i]), 32'd1 << (i % N));
    end

    // Contention between req1 and req3 with pointer at 1
    apply_reset();
    req_valid = 4'b0010; rand_ops();
    cycle();
    clear_logs();
    req_valid = 4'b1010;
    repeat (100) begin rand_ops(); cycle(); end
    req_valid = '0;
    repeat (L + 2) cycle();
    if (g_log.size() >= 2) begin
      chk("cont_first", 32'(g_log[0]), 32'b1000);
      chk("cont_second", 32'(g_log[1]), 32'b0010);
    end
    n1 = 0; n3 = 0;
    foreach (g_log[i]) begin
      if (g_log[i] == 4'b0010) n1++;
      if (g_log[i] == 4'b1000) n3++;
    end
    chk("cont_req1", n1, 50);
    chk("cont_req3", n3, 50);

    // Back-to-back distinct operands on req2
    apply_reset();
    clear_logs();
    req_valid = 4'b0100;
    req_a[2] = 32'h3F800000; req_b[2] = 32'h34000000;
    cycle();
    req_b[2] = 32'hB3800000;
    cycle();
    req_valid = '0;
    repeat (L + 3) cycle();
    chk("b2b_count", r_dat.size(), 2);
    if (r_dat.size() == 2) begin
      chk("b2b_data0", r_dat[0], 32'h3F800001);
      chk("b2b_data1", r_dat[1], 32'h3F7FFFFF);
      chk("b2b_owner", 32'(r_vld[1]), 32'b0100);
    end

    // Reset with ops in flight
    apply_reset();
    req_valid = 4'b0001;
    repeat (3) begin rand_ops(); cycle(); end
    req_valid = 4'b0010; rand_ops();
    cycle();
    apply_reset();
    clear_logs();
    repeat (10) cycle();
    chk("midrst_no_res", r_cyc.size(), 0);
    req_valid = 4'hF; rand_ops();
    cycle();
    req_valid = '0;
    if (g_log.size() == 1) chk("midrst_first_gnt", 32'(g_log[0]), 32'b0001);
    repeat (L + 2) cycle();

    // Idle gap
    clear_logs();
    repeat (10) cycle();
    chk("idle_no_res", r_cyc.size(), 0);

    // Random traffic
    clear_logs();
    repeat (400) begin
      req_valid = N'($urandom_range(0, (1 << N) - 1));
      rand_ops();
      cycle();
    end
    req_valid = '0;
    repeat (L + 2) cycle();
    chk("rand_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
